// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-count interface.
// State encoding, default widths and a reference Gray-to-binary helper.
package gray_pkg;

   localparam int GRAY_W_DEF = 3;
   localparam int WRAP_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_LOCK = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   // Prefix-XOR from the MSB down; upper unused bits must be zero.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] In_gray,
   output logic [WIDTH-1:0] Bin_comb
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign Bin_comb[i] = ^In_gray[WIDTH-1:i];
   end

endmodule

// File: rtl/gray_decoder.sv
// Receive end of the Gray-count interface: decodes, checks that each
// sample repeats or advances by one, counts wraps and flags violations.
module gray_decoder
   import gray_pkg::*;
#(
   parameter int WIDTH  = GRAY_W_DEF,
   parameter int WRAP_W = WRAP_W_DEF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              In_valid,
   input  logic [WIDTH-1:0]  In_gray,
   input  logic              Resync,
   output logic [WIDTH-1:0]  Bin,
   output logic              Out_valid,
   output logic              Wrap,
   output logic [WRAP_W-1:0] Wrap_count,
   output logic              Overflow,
   output logic              Error
);

   state_t              r_state;
   logic [WIDTH-1:0]    r_bin;
   logic                r_out_valid;
   logic                r_wrap;
   logic [WRAP_W-1:0]   r_wrap_count;
   logic                r_overflow;
   logic                r_error;

   logic [WIDTH-1:0]    w_dec;
   logic [WIDTH-1:0]    w_succ;
   logic                w_repeat;
   logic                w_next;
   logic                w_prev_max;
   logic                w_cnt_max;

   gray_to_bin #(.WIDTH(WIDTH)) u_g2b (
      .In_gray  (In_gray),
      .Bin_comb (w_dec)
   );

   // Successor compare wraps naturally at WIDTH bits.
   assign w_succ     = r_bin + 1'b1;
   assign w_repeat   = (w_dec == r_bin);
   assign w_next     = (w_dec == w_succ);
   assign w_prev_max = &r_bin;
   assign w_cnt_max  = &r_wrap_count;

   // Tracking FSM with registered outputs; pulses default low each cycle.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state      <= ST_INIT;
         r_bin        <= '0;
         r_out_valid  <= 1'b0;
         r_wrap       <= 1'b0;
         r_wrap_count <= '0;
         r_overflow   <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         r_wrap      <= 1'b0;
         if (Resync) begin
            r_state <= ST_INIT;
            r_error <= 1'b0;
         end else begin
            unique case (r_state)
               ST_INIT: begin
                  if (In_valid) begin
                     r_bin       <= w_dec;
                     r_out_valid <= 1'b1;
                     r_state     <= ST_LOCK;
                  end
               end
               ST_LOCK: begin
                  if (In_valid) begin
                     if (w_repeat) begin
                        r_out_valid <= 1'b1;
                     end else if (w_next) begin
                        r_bin       <= w_dec;
                        r_out_valid <= 1'b1;
                        if (w_prev_max) begin
                           r_wrap       <= 1'b1;
                           r_wrap_count <= r_wrap_count + 1'b1;
                           if (w_cnt_max) begin
                              r_overflow <= 1'b1;
                           end
                        end
                     end else begin
                        r_error <= 1'b1;
                        r_state <= ST_ERR;
                     end
                  end
               end
               ST_ERR: begin
                  r_state <= ST_ERR;
               end
               default: begin
                  r_state <= ST_INIT;
               end
            endcase
         end
      end
   end

   assign Bin        = r_bin;
   assign Out_valid  = r_out_valid;
   assign Wrap       = r_wrap;
   assign Wrap_count = r_wrap_count;
   assign Overflow   = r_overflow;
   assign Error      = r_error;

endmodule
